// File: rtl/lut_pkg.sv
// Shared definitions for the LUT neuron loader: FSM states, default
// geometry and the configuration-beat constants.
package lut_pkg;

  // Width of one configuration beat on cfg_data.
  localparam int CFG_BITS = 8;

  // Default lookup geometry.
  localparam int IN_BITS_DEF  = 8;
  localparam int OUT_BITS_DEF = 2;

  // Number of cfg_data beats needed to fill a table of the given geometry.
  function automatic int beat_count(input int in_bits, input int out_bits);
    return ((2 ** in_bits) * out_bits) / CFG_BITS;
  endfunction

  // Beats for a full load at the default geometry (64).
  localparam int BEATS_DEF = beat_count(IN_BITS_DEF, OUT_BITS_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/lut_ram.sv
// Lookup-table storage: one beat-wide write port and a registered entry-wide
// read port. With LUT_READBACK_EN defined, a second registered read port is
// added for table readback.
module lut_ram
  import lut_pkg::*;
#(
  parameter  int ADDR_BITS  = IN_BITS_DEF,
  parameter  int DATA_BITS  = OUT_BITS_DEF,
  localparam int SEL_BITS   = $clog2(CFG_BITS / DATA_BITS),
  localparam int WADDR_BITS = ADDR_BITS - SEL_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [WADDR_BITS-1:0] waddr,
  input  logic [CFG_BITS-1:0]   wdata,
  input  logic                  rd_en,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic [DATA_BITS-1:0]  rd_data
`ifdef LUT_READBACK_EN
  ,
  input  logic                  rb_en,
  input  logic [ADDR_BITS-1:0]  rb_addr,
  output logic [DATA_BITS-1:0]  rb_data
`endif
);

  // Each word holds one configuration beat, i.e. CFG_BITS/DATA_BITS entries.
  logic [CFG_BITS-1:0] mem [2 ** WADDR_BITS];

  // Select one entry: upper address bits pick the word, lower bits the lane.
  function automatic logic [DATA_BITS-1:0] pick(input logic [ADDR_BITS-1:0] a);
    logic [CFG_BITS-1:0] w;
    w = mem[a[ADDR_BITS-1:SEL_BITS]];
    return w[int'(a[SEL_BITS-1:0]) * DATA_BITS +: DATA_BITS];
  endfunction

  // Beat write into storage.
  // NOTE: the storage array has no reset; clearing it would stop it mapping
  // onto RAM primitives, and the loader never trusts it until a full reload.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered lookup read; holds its value when not enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= pick(rd_addr);
  end

`ifdef LUT_READBACK_EN
  // Registered readback read; a same-cycle write returns the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rb_data <= '0;
    else if (rb_en) rb_data <= pick(rb_addr);
  end
`endif

endmodule

// File: rtl/lut_neuron_loader.sv
// LUT neuron: streams a lookup table in over cfg_* beats, then answers one
// registered lookup per cycle. Optional readback port enabled by defining
// LUT_READBACK_EN.
module lut_neuron_loader
  import lut_pkg::*;
#(
  parameter int IN_BITS  = IN_BITS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                table_valid,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
`ifdef LUT_READBACK_EN
  ,
  input  logic                rb_req,
  input  logic [IN_BITS-1:0]  rb_addr,
  output logic                rb_valid,
  output logic [OUT_BITS-1:0] rb_data
`endif
);

  localparam int                CNT_BITS = IN_BITS - $clog2(CFG_BITS / OUT_BITS);
  localparam int                BEATS    = beat_count(IN_BITS, OUT_BITS);
  localparam logic [CNT_BITS-1:0] LAST   = CNT_BITS'(BEATS - 1);

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                wr_en;
  logic                lookup;

  assign cfg_ready   = (state_q == LOAD);
  assign table_valid = (state_q == RUN);
  assign lookup      = in_valid && (state_q == RUN);

  // State and beat-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_valid <= lookup;
    end
  end

  // Next-state, beat counting and write strobe. cfg_start wins over any beat
  // presented in the same cycle, so that beat is dropped.
  // NOTE: every output of this block gets a default first, otherwise paths
  // that skip an assignment would infer latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    if (cfg_start) begin
      state_d = LOAD;
      cnt_d   = '0;
    end else if (state_q == LOAD && cfg_valid) begin
      wr_en = 1'b1;
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        state_d = RUN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

`ifdef LUT_READBACK_EN
  // Readback valid follows the request by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rb_valid <= 1'b0;
    else     rb_valid <= rb_req;
  end
`endif

  lut_ram #(
    .ADDR_BITS (IN_BITS),
    .DATA_BITS (OUT_BITS)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en),
    .waddr   (cnt_q),
    .wdata   (cfg_data),
    .rd_en   (lookup),
    .rd_addr (in_data),
    .rd_data (out_data)
`ifdef LUT_READBACK_EN
    ,
    .rb_en   (rb_req),
    .rb_addr (rb_addr),
    .rb_data (rb_data)
`endif
  );

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Self-checking bench for lut_neuron_loader: directed loads plus randomized
// beat/lookup traffic checked against a table model. Readback checks are
// included when LUT_READBACK_EN is defined.
module tb_lut_neuron_loader;
  import lut_pkg::*;

  localparam int IN_BITS  = IN_BITS_DEF;
  localparam int OUT_BITS = OUT_BITS_DEF;
  localparam int BEATS    = BEATS_DEF;
  localparam int ENTRIES  = 2 ** IN_BITS;
  localparam int PER_BEAT = CFG_BITS / OUT_BITS;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                cfg_start = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [CFG_BITS-1:0] cfg_data = '0;
  logic                table_valid;
  logic                in_valid = 1'b0;
  logic [IN_BITS-1:0]  in_data = '0;
  logic                out_valid;
  logic [OUT_BITS-1:0] out_data;
`ifdef LUT_READBACK_EN
  logic                rb_req = 1'b0;
  logic [IN_BITS-1:0]  rb_addr = '0;
  logic                rb_valid;
  logic [OUT_BITS-1:0] rb_data;
`endif

  always #5 clk = ~clk;

  lut_neuron_loader #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_start   (cfg_start),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_data    (cfg_data),
    .table_valid (table_valid),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_data    (out_data)
`ifdef LUT_READBACK_EN
    ,
    .rb_req      (rb_req),
    .rb_addr     (rb_addr),
    .rb_valid    (rb_valid),
    .rb_data     (rb_data)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the table as a flat array of entries, the number of
  // beats accepted so far in the current load, and what out_data should hold.
  logic [OUT_BITS-1:0] model [ENTRIES];
  logic [CFG_BITS-1:0] stim  [BEATS];
  int                  mbeat  = 0;
  bit                  mvalid = 1'b0;
  logic [OUT_BITS-1:0] exp_out = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Beat n fills entries n*PER_BEAT .. n*PER_BEAT+PER_BEAT-1, low lane first.
  task automatic model_beat(input logic [CFG_BITS-1:0] d);
    for (int k = 0; k < PER_BEAT; k++)
      model[mbeat * PER_BEAT + k] = d[k * OUT_BITS +: OUT_BITS];
    mbeat++;
    if (mbeat == BEATS) begin
      mbeat  = 0;
      mvalid = 1'b1;
    end
  endtask

  task automatic fill_stim(input int mode);
    for (int i = 0; i < BEATS; i++) begin
      case (mode)
        0:       stim[i] = 8'hFF;
        1:       stim[i] = (i == 0) ? 8'h1B : 8'h00;
        default: stim[i] = 8'($urandom);
      endcase
    end
  endtask

  // One-cycle cfg_start; optionally with a beat that must be discarded.
  task automatic pulse_start(input bit with_beat);
    cfg_start = 1'b1;
    cfg_valid = with_beat;
    cfg_data  = 8'($urandom);
    in_valid  = 1'b0;
    step();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    mbeat     = 0;
    mvalid    = 1'b0;
    check("start_table_valid", 32'(table_valid), 0);
  endtask

  // Present beats until n are accepted; lookups issued meanwhile must be ignored.
  task automatic feed(input int n, input bit rnd);
    int got    = 0;
    int budget = 0;
    while (got < n && budget < 5000) begin
      cfg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_data  = stim[mbeat];
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = IN_BITS'($urandom);
      check("cfg_ready_load", 32'(cfg_ready), 1);
      if (cfg_valid) begin
        model_beat(cfg_data);
        got++;
      end
      step();
      check("table_valid", 32'(table_valid), 32'(mvalid));
      check("out_valid_load", 32'(out_valid), 0);
      check("out_data_hold", 32'(out_data), 32'(exp_out));
      budget++;
    end
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    if (got < n) check("feed_budget", 32'(got), 32'(n));
    if (mvalid) check("cfg_ready_run", 32'(cfg_ready), 0);
  endtask

  // Random lookups in RUN; the last one is always valid.
  task automatic lookups(input int n);
    for (int i = 0; i < n; i++) begin
      logic               v;
      logic [IN_BITS-1:0] a;
      v = (i == n - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      a = IN_BITS'($urandom);
      in_valid = v;
      in_data  = a;
      step();
      check("out_valid", 32'(out_valid), 32'(v));
      if (v) begin
        exp_out = model[a];
        check("out_data", 32'(out_data), 32'(exp_out));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic lookup_one(input logic [IN_BITS-1:0] a, input logic [OUT_BITS-1:0] e);
    in_valid = 1'b1;
    in_data  = a;
    step();
    in_valid = 1'b0;
    exp_out  = e;
    check($sformatf("lookup_%02h_valid", a), 32'(out_valid), 1);
    check($sformatf("lookup_%02h_data", a), 32'(out_data), 32'(e));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    #1 rst = 1'b1;
    #2;
    check("rst_cfg_ready", 32'(cfg_ready), 0);
    check("rst_table_valid", 32'(table_valid), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
`ifdef LUT_READBACK_EN
    check("rst_rb_valid", 32'(rb_valid), 0);
    check("rst_rb_data", 32'(rb_data), 0);
`endif
    step();
    step();
    rst = 1'b0;

    // Lookups and stray beats in IDLE are ignored.
    in_valid  = 1'b1;
    cfg_valid = 1'b1;
    step();
    check("idle_out_valid", 32'(out_valid), 0);
    check("idle_cfg_ready", 32'(cfg_ready), 0);
    in_valid  = 1'b0;
    cfg_valid = 1'b0;

    // All-ones table.
    fill_stim(0);
    pulse_start(1'b0);
    feed(BEATS, 1'b0);
    lookup_one(8'h00, 2'b11);
    lookups(40);

    // Reset mid-load aborts: outputs clear at once, table stays invalid.
    fill_stim(2);
    pulse_start(1'b0);
    feed(20, 1'b1);
    rst = 1'b1;
    #1;
    exp_out = '0;
    mvalid  = 1'b0;
    mbeat   = 0;
    check("abort_cfg_ready", 32'(cfg_ready), 0);
    check("abort_table_valid", 32'(table_valid), 0);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_out_data", 32'(out_data), 0);
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = IN_BITS'($urandom);
    step();
    step();
    in_valid = 1'b0;
    check("abort_idle_out_valid", 32'(out_valid), 0);
    check("abort_idle_table_valid", 32'(table_valid), 0);

    // Packed-lane ordering: only beat 0 non-zero.
    fill_stim(1);
    pulse_start(1'b0);
    feed(BEATS, 1'b1);
    lookup_one(8'h00, 2'b11);
    lookup_one(8'h01, 2'b10);
    lookup_one(8'h02, 2'b01);
    lookup_one(8'h03, 2'b00);
    lookup_one(8'h04, 2'b00);
`ifdef LUT_READBACK_EN
    rb_req  = 1'b1;
    rb_addr = 8'h01;
    step();
    rb_req = 1'b0;
    check("rb_valid", 32'(rb_valid), 1);
    check("rb_data", 32'(rb_data), 32'(2'b10));
    step();
    check("rb_valid_drop", 32'(rb_valid), 0);
`endif

    // Random data with randomly gapped cfg_valid.
    fill_stim(2);
    pulse_start(1'b0);
    feed(BEATS, 1'b1);
    lookups(200);

    // Restart after beat 30 with a beat in the restart cycle; that beat is
    // dropped and a full further load is needed.
    fill_stim(2);
    pulse_start(1'b0);
    feed(31, 1'b1);
    pulse_start(1'b1);
    feed(BEATS - 1, 1'b1);
    check("restart_not_yet_valid", 32'(table_valid), 0);
    feed(1, 1'b1);
    check("restart_valid", 32'(table_valid), 1);
    lookups(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
